rca_seq_adder_ctrl: RTL and testbench
=====================================

Name: rca_seq_adder_ctrl

Overview:
- Multi-cycle wide adder controller. Sequences one 4-bit ripple-carry slice, built from the existing full_adder cell, across NIBBLES nibbles of a wide operand pair.
- Processes one nibble per enabled cycle, least significant first, and carries the ripple through a carry register.
- Valid/ready handshakes on both input and output let upstream and downstream logic stall it.
- Sits between operand-producing logic and result consumers where a full-width combinational adder is too large or too slow.

Parameters:
- NIBBLES, 4, number of 4-bit slices processed. Operand width W = 4*NIBBLES. Legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  global advance qualifier; when 0, all state and outputs hold.
- in_valid  input  1  operand pair a/b/cin is valid.
- in_ready  output  1  controller can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  sum holds a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  W+1  result; sum[W] is the final carry-out.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - state=IDLE, nibble index=0, carry register=0, operand registers=0, sum=0.
  - in_ready=1, out_valid=0, busy=0.
  - Applies at any time, including mid-ADD or in DONE. The in-flight operation is discarded with no partial result.
- Every registered update below is additionally qualified by enable=1. With enable=0, state, index, carry, sum and all outputs hold their values, and no handshake completes.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready&&enable: capture a, b, cin into internal registers; clear sum to 0; set index=0; move to ADD.
  - Operand changes after capture have no effect.
- ADD:
  - in_ready=0.
  - Each enabled cycle, the slice adds A[4i+3:4i] + B[4i+3:4i] + carry_reg, where i=index.
  - The 4-bit slice sum is written to sum[4i+3:4i]; carry_reg takes the slice carry-out; index increments.
  - On the cycle where index==NIBBLES-1, the slice carry-out is also written to sum[W], and state moves to DONE.
  - The slice path is purely combinational within one cycle: one nibble per cycle, no extra pipeline stage.
- DONE:
  - out_valid=1; sum is stable and equals a+b+cin, zero-extended to W+1 bits.
  - On out_valid&&out_ready&&enable: move to IDLE and set out_valid=0.
  - sum holds its value in IDLE until the next capture.
- Latency: with enable held at 1 and out_ready=1, out_valid rises NIBBLES cycles after the accepting edge and falls one cycle later.
- Throughput: at most one operation per NIBBLES+2 cycles. in_ready=0 in DONE, so the same cycle cannot both hand off a result and accept new operands.
- Arithmetic: unsigned. Overflow is never lost because the carry appears in sum[W]. The maximum result is 2*(2^W-1)+1 = 2^(W+1)-1.
- NIBBLES=1: ADD lasts exactly one cycle, and sum[4] is the carry of that single slice.
- Holding in_valid high in ADD or DONE is legal. It is not accepted until the controller returns to IDLE.
- No illegal states are reachable. Unused state encodings recover to IDLE.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid high 4 cycles after acceptance, sum=0x05555, then back to IDLE with in_ready=1.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x10000; carry ripples through all four nibbles. Then a=0xFFFF, b=0xFFFF, cin=1 -> sum=0x1FFFF.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and sum=0x05555 held, in_ready=0. Then out_ready=1 -> one-cycle handoff and return to IDLE.
- Stall: drop enable for 3 cycles after nibble 1 of 0x0F0F+0x0101 -> index, carry and busy frozen; completion is delayed by exactly 3 cycles; sum=0x01010.
- Reset mid-ADD: assert rst_n=0 after 2 nibbles -> immediately sum=0, out_valid=0, in_ready=1. A new 0x0001+0x0001 then yields sum=0x00002.
- NIBBLES=1: a=0xF, b=0x1, cin=1 -> out_valid 1 cycle after acceptance, sum=0x11.

Source files
------------

// File: rtl/rca_seq_adder_ctrl.sv
// ---------------------------------------------------------------------------
// rca_seq_adder_ctrl
//
// Multi-cycle wide adder. A single 4-bit ripple-carry slice, built from four
// full_adder cells, is stepped across NIBBLES nibbles of a captured operand
// pair. It handles one nibble per enabled cycle, least significant first. The
// ripple between nibbles is held in a carry register.
//
// Ports
//   clk        : system clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : global advance qualifier; 0 freezes all state and outputs
//   in_valid   : a/b/cin hold a valid operand pair
//   in_ready   : controller can accept operands (IDLE only)
//   a, b       : W-bit operands, W = 4*NIBBLES
//   cin        : carry into nibble 0
//   out_valid  : sum holds a completed result (DONE only)
//   out_ready  : consumer accepts the result
//   sum        : W+1-bit result, sum[W] is the final carry-out
//   busy       : high while an operation is in ADD or DONE
//
// Handshake: a transfer happens on a rising edge where valid, ready and
// enable are all 1. Ready never depends on the partner's valid, and a held
// valid is only consumed once the state accepts it.
// ---------------------------------------------------------------------------
module rca_seq_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES:0]     sum,
  output logic                   busy
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W:0]       sum_q;

  // Single-bit full adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic x, input logic y,
                                            input logic ci);
    logic s;
    logic co;
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
    return {co, s};
  endfunction

  // Current nibble selection: bit offset is idx*4.
  logic [IDX_W+1:0] bit_off;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       slice_sum;
  logic [4:0]       slice_carry;

  assign bit_off = {idx, 2'b00};
  assign nib_a   = a_q[bit_off +: 4];
  assign nib_b   = b_q[bit_off +: 4];

  // Four-cell ripple chain, purely combinational within one cycle.
  always_comb begin
    logic [1:0] fa;
    slice_sum      = '0;
    slice_carry    = '0;
    slice_carry[0] = carry_q;
    for (int j = 0; j < 4; j++) begin
      fa               = full_adder(nib_a[j], nib_b[j], slice_carry[j]);
      slice_sum[j]     = fa[0];
      slice_carry[j+1] = fa[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum_q   <= '0;
            idx     <= '0;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          sum_q[bit_off +: 4] <= slice_sum;
          carry_q             <= slice_carry[4];
          if (idx == LAST_IDX) begin
            // Final slice: its carry-out becomes the top result bit.
            sum_q[W] <= slice_carry[4];
            idx      <= '0;
            state    <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded straight from state so reset values follow directly.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_ADD) || (state == S_DONE);
  assign sum       = sum_q;

endmodule

// File: tb/tb_rca_seq_adder_ctrl.sv
module tb_rca_seq_adder_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (NIBBLES=4) ----------------
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    sum;
  logic          busy;

  rca_seq_adder_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .busy(busy)
  );

  // ---------------- DUT (NIBBLES=1) ----------------
  logic        en1 = 1'b0;
  logic        iv1 = 1'b0;
  logic        ir1;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        c1 = 1'b0;
  logic        ov1;
  logic        or1 = 1'b1;
  logic [4:0]  s1;
  logic        bz1;

  rca_seq_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .out_ready(or1),
    .sum(s1), .busy(bz1)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 adding, 2 result held. mk counts nibbles finished.
  // The visible sum after k nibbles is the low 4k bits of a+b+cin, with the
  // full W+1-bit total once all nibbles are done.
  int         mph = 0;
  int         mk = 0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mb = '0;
  logic       mc = 1'b0;
  logic [W:0] msum = '0;
  bit         cmp_on = 1'b0;

  function automatic logic [W:0] partial(input int k, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic c);
    logic [63:0] m;
    logic [63:0] s;
    m = (64'd1 << (4 * k)) - 64'd1;
    s = ({48'd0, x} & m) + ({48'd0, y} & m) + {63'd0, c};
    if (k == N) return s[W:0];
    return s[W:0] & m[W:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mph  <= 0;
      mk   <= 0;
      msum <= '0;
    end else if (enable) begin
      case (mph)
        0: if (in_valid) begin
          ma <= a; mb <= b; mc <= cin;
          msum <= '0; mk <= 0; mph <= 1;
        end
        1: begin
          msum <= partial(mk + 1, ma, mb, mc);
          mk   <= mk + 1;
          if (mk + 1 == N) mph <= 2;
        end
        default: if (out_ready) mph <= 0;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("in_ready",  {63'd0, in_ready},  {63'd0, mph == 0});
      chk("out_valid", {63'd0, out_valid}, {63'd0, mph == 2});
      chk("busy",      {63'd0, busy},      {63'd0, mph != 0});
      chk("sum",       {47'd0, sum},       {47'd0, msum});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tbv, input logic tc,
                        input int stall_at, input int hold,
                        input int exp_lat, input logic [W:0] exp_sum);
    bit acc;
    int k;
    a = ta; b = tbv; cin = tc; in_valid = 1'b1;
    out_ready = (hold == 0);
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready && enable;
      @(posedge clk); #1;
    end
    chk({tag, "_accept"}, {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    k = 0;
    while (!out_valid && k < 100) begin
      if (k == stall_at) enable = 1'b0;
      if (stall_at >= 0 && k == stall_at + 3) enable = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_lat));
    chk({tag, "_sum"}, {47'd0, sum}, {47'd0, exp_sum});
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
      chk({tag, "_hold_sum"}, {47'd0, sum}, {47'd0, exp_sum});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_handoff_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_handoff_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_sum_kept"}, {47'd0, sum}, {47'd0, exp_sum});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rc;
    logic [4:0] e1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_sum",       {47'd0, sum},       64'd0);
    rst_n = 1'b1;
    enable = 1'b1;
    cmp_on = 1'b1;
    @(posedge clk); #1;

    // Directed operations with hand-computed results
    run_op("basic",  16'h1234, 16'h4321, 1'b0, -1, 0, 4, 17'h05555);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, -1, 0, 4, 17'h10000);
    run_op("max",    16'hFFFF, 16'hFFFF, 1'b1, -1, 0, 4, 17'h1FFFF);
    run_op("bp",     16'h1234, 16'h4321, 1'b0, -1, 5, 4, 17'h05555);
    run_op("stall",  16'h0F0F, 16'h0101, 1'b0,  2, 0, 7, 17'h01010);

    // Reset after two nibbles of an operation
    a = 16'h9999; b = 16'h7777; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum",       {47'd0, sum},       64'd0);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, -1, 0, 4, 17'h00002);

    // NIBBLES=1 instance: first the hand-computed case, then random ones
    en1 = 1'b1;
    for (int t = 0; t < 9; t++) begin
      if (t == 0) begin ra = 4'hF; rb = 4'h1; rc = 1'b1; end
      else begin ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom); end
      e1 = {1'b0, ra} + {1'b0, rb} + {4'd0, rc};
      if (t == 0) chk("n1_model_pin", {59'd0, e1}, 64'h11);
      exp_q.push_back({12'd0, e1});
      a1 = ra; b1 = rb; c1 = rc; iv1 = 1'b1;
      @(negedge clk);
      chk("n1_in_ready", {63'd0, ir1}, 64'd1);
      @(posedge clk); #1;
      iv1 = 1'b0;
      chk("n1_add_valid", {63'd0, ov1}, 64'd0);
      chk("n1_add_busy",  {63'd0, bz1}, 64'd1);
      @(posedge clk); #1;
      chk("n1_done_valid", {63'd0, ov1}, 64'd1);
      chk("n1_sum", {59'd0, s1}, {47'd0, exp_q.pop_front()});
      @(posedge clk); #1;
      chk("n1_back_idle", {63'd0, ir1}, 64'd1);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      in_valid  = 1'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    enable = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
